// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, shift selectors and result-entry types
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  localparam logic SEL_SHL = 1'b0;
  localparam logic SEL_SAR = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              sel;
    logic              z;
    logic              n;
    logic              v;
  } shift_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  // Flags are frozen into the entry at push time.
  function automatic shift_entry_t make_entry(input logic [DATA_W-1:0] result,
                                              input logic sel,
                                              input logic of);
    shift_entry_t e;
    e.result = result;
    e.sel    = sel;
    e.z      = (result == '0);
    e.n      = result[DATA_W-1];
    e.v      = of;
    return e;
  endfunction

endpackage

// File: rtl/shift_result_stage_if.sv
// rtl/shift_result_stage_if.sv - shifter-result handshake bundle between shifter, stage and consumer
interface shift_result_stage_if;
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_of;
  logic              in_sel;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_sel;
  logic              out_z;
  logic              out_n;
  logic              out_v;

  modport master (
    output in_valid, in_result, in_of, in_sel, out_ready,
    input  in_ready, out_valid, out_result, out_sel, out_z, out_n, out_v
  );

  modport slave (
    input  in_valid, in_result, in_of, in_sel, out_ready,
    output in_ready, out_valid, out_result, out_sel, out_z, out_n, out_v
  );

endinterface

// File: rtl/fifo2_reg.sv
// rtl/fifo2_reg.sv - two-entry register FIFO, outputs and in_ready from registers only
module fifo2_reg
  import alu_pkg::*;
#(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_t         state, state_nxt;
  logic [W-1:0] head, tail;
  logic         push, pop;
  logic         load_head, load_tail, promote;

  assign in_ready  = (state != OCC_FULL);
  assign out_valid = (state != OCC_EMPTY);
  assign out_data  = head;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OCC_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    load_tail = 1'b0;
    promote   = 1'b0;
    case (state)
      OCC_EMPTY: begin
        if (push) begin
          state_nxt = OCC_ONE;
          load_head = 1'b1;
        end
      end
      OCC_ONE: begin
        // Push with pop replaces the head in place; occupancy stays one.
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          state_nxt = OCC_FULL;
          load_tail = 1'b1;
        end else if (pop) begin
          state_nxt = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          state_nxt = OCC_ONE;
          promote   = 1'b1;
        end
      end
      default: state_nxt = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (load_head)    head <= in_data;
      else if (promote) head <= tail;
      if (load_tail)    tail <= in_data;
    end
  end

endmodule

// File: rtl/shift_result_stage.sv
// rtl/shift_result_stage.sv - registered shifter result buffer with flags, sticky overflow and event counter
module shift_result_stage
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  shift_result_stage_if.slave bus,
  input  logic                clr_status,
  output logic                ovf_sticky,
  output logic [CNT_W-1:0]    ovf_count
);

  shift_entry_t entry_in, entry_out;
  logic         ovf_push;

  assign entry_in = make_entry(bus.in_result, bus.in_sel, bus.in_of);

  fifo2_reg #(.W($bits(shift_entry_t))) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (entry_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (entry_out)
  );

  assign bus.out_result = entry_out.result;
  assign bus.out_sel    = entry_out.sel;
  assign bus.out_z      = entry_out.z;
  assign bus.out_n      = entry_out.n;
  assign bus.out_v      = entry_out.v;

  assign ovf_push = bus.in_valid && bus.in_ready && bus.in_of;

  // A qualifying push beats a simultaneous clear: the new event is counted from one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (ovf_push) begin
      ovf_sticky <= 1'b1;
      if (clr_status)          ovf_count <= CNT_W'(1);
      else if (ovf_count != '1) ovf_count <= ovf_count + CNT_W'(1);
    end else if (clr_status) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule
